// File: rtl/dut_rr_share_pkg.sv
// Shared constants, width helpers and the tag type for the round-robin
// request sharer and its in-order tag FIFO.
package dut_rr_share_pkg;

  localparam int unsigned payload_width_lp = 32'd80;
  localparam int unsigned num_req_lp       = 32'd4;
  localparam int unsigned tag_els_lp       = 32'd4;

  // Bits needed to name one of n items (at least one bit).
  function automatic int unsigned tag_width(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

  // Bits needed to hold an occupancy count from 0 to els inclusive.
  function automatic int unsigned count_width(input int unsigned els);
    return $clog2(els + 32'd1);
  endfunction

  localparam int unsigned tag_width_lp = tag_width(num_req_lp);

  typedef logic [tag_width_lp-1:0] tag_t;

endpackage

// File: rtl/dut_rr_share_chk.sv
// Protocol checks for the request sharer.
module dut_rr_share_chk #(
  parameter int unsigned tag_els_p = 4,
  parameter int unsigned cnt_w_p   = 3
) (
  input logic               clk_i,
  input logic               reset_i,
  input logic               dut_v_i,
  input logic               head_v_i,
  input logic [cnt_w_p-1:0] count_i
);

  // A DUT response must always have an issuing requester to return to.
  resp_has_head_a: assert property (@(posedge clk_i) disable iff (reset_i)
    dut_v_i |-> head_v_i);

  // Occupancy never exceeds the tag storage.
  count_in_range_a: assert property (@(posedge clk_i) disable iff (reset_i)
    count_i <= cnt_w_p'(tag_els_p));

endmodule

// File: rtl/dut_rr_share_tag_fifo.sv
// In-order tag FIFO: remembers which requester issued each in-flight
// request so DUT responses can be routed back in issue order.
module dut_rr_share_tag_fifo
  import dut_rr_share_pkg::*;
#(
  parameter int unsigned els_p   = 4,
  parameter int unsigned width_p = 2
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            push_i,
  input  logic                            pop_i,
  input  logic [width_p-1:0]              data_i,
  output logic [width_p-1:0]              data_o,
  output logic                            full_o,
  output logic                            empty_o,
  output logic [count_width(els_p)-1:0]   count_o
);

  localparam int unsigned ptr_w_lp = tag_width(els_p);
  localparam int unsigned cnt_w_lp = count_width(els_p);
  localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(els_p - 32'd1);
  localparam logic [cnt_w_lp-1:0] els_cnt_lp  = cnt_w_lp'(els_p);

  logic [width_p-1:0]  mem_q [els_p];
  logic [ptr_w_lp-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [cnt_w_lp-1:0] cnt_q, cnt_d;
  logic                do_push_s, do_pop_s;

  assign full_o    = (cnt_q == els_cnt_lp);
  assign empty_o   = (cnt_q == '0);
  assign data_o    = mem_q[rd_q];
  assign count_o   = cnt_q;
  // Never overrun or underrun, whatever the caller asks for.
  assign do_push_s = push_i & ~full_o;
  assign do_pop_s  = pop_i & ~empty_o;

  // Next pointers wrap at els_p (not necessarily a power of two); count follows push/pop.
  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (do_push_s) begin
      wr_d = (wr_q == last_ptr_lp) ? '0 : wr_q + ptr_w_lp'(1'b1);
    end else begin
      wr_d = wr_q;
    end
    if (do_pop_s) begin
      rd_d = (rd_q == last_ptr_lp) ? '0 : rd_q + ptr_w_lp'(1'b1);
    end else begin
      rd_d = rd_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   cnt_d = cnt_q + cnt_w_lp'(1'b1);
      2'b01:   cnt_d = cnt_q - cnt_w_lp'(1'b1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and count state; reset empties the FIFO.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Tag storage; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk_i) begin
    if (do_push_s) begin
      mem_q[wr_q] <= data_i;
    end
  end

endmodule

// File: rtl/dut_rr_share.sv
// Shares one valid/ready DUT among several requesters: round-robin grant on
// the request side, in-order tag FIFO to route responses back.
module dut_rr_share
  import dut_rr_share_pkg::*;
#(
  parameter int unsigned payload_width_p = 80,
  parameter int unsigned num_req_p       = 4,
  parameter int unsigned tag_els_p       = 4
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic [num_req_p-1:0]                 req_v_i,
  input  logic [num_req_p*payload_width_p-1:0] req_data_i,
  output logic [num_req_p-1:0]                 req_ready_o,
  output logic                                 dut_v_o,
  output logic [payload_width_p-1:0]           dut_data_o,
  input  logic                                 dut_ready_i,
  input  logic                                 dut_v_i,
  input  logic [payload_width_p-1:0]           dut_data_i,
  output logic                                 dut_ready_o,
  output logic [num_req_p-1:0]                 resp_v_o,
  output logic [payload_width_p-1:0]           resp_data_o,
  input  logic [num_req_p-1:0]                 resp_ready_i
);

  localparam int unsigned tag_w_lp = tag_width(num_req_p);
  localparam int unsigned cnt_w_lp = count_width(tag_els_p);
  localparam logic [tag_w_lp-1:0] last_req_lp = tag_w_lp'(num_req_p - 32'd1);
  localparam logic [tag_w_lp:0]   num_req_w_lp = (tag_w_lp+1)'(num_req_p);

  logic [tag_w_lp-1:0] ptr_q, ptr_d, winner_s, head_s, fifo_head_s;
  logic                any_v_s, tag_full_s, tag_empty_s, head_v_s;
  logic                hs_in_s, hs_out_s, bypass_s, push_s, pop_s;
  logic [cnt_w_lp-1:0] tag_count_s;

  // First valid requester at or after the pointer, wrapping around.
  always_comb begin
    logic [tag_w_lp:0]   sum_v;
    logic [tag_w_lp-1:0] idx_v;
    logic                found_v, hit_v;
    found_v  = 1'b0;
    hit_v    = 1'b0;
    sum_v    = '0;
    idx_v    = '0;
    winner_s = ptr_q;
    for (int k = 0; k < num_req_p; k++) begin
      sum_v    = {1'b0, ptr_q} + (tag_w_lp+1)'(k);
      idx_v    = (sum_v >= num_req_w_lp) ? tag_w_lp'(sum_v - num_req_w_lp) : tag_w_lp'(sum_v);
      hit_v    = ~found_v & req_v_i[idx_v];
      winner_s = hit_v ? idx_v : winner_s;
      found_v  = found_v | hit_v;
    end
  end

  assign any_v_s    = |req_v_i;
  // dut_v_o deliberately ignores dut_ready_i; a full FIFO blocks even if it pops this cycle.
  assign dut_v_o    = ~reset_i & any_v_s & ~tag_full_s;
  assign dut_data_o = req_data_i[winner_s*payload_width_p +: payload_width_p];
  assign hs_in_s    = dut_v_o & dut_ready_i;

  // With an empty FIFO the request being issued now is the head, so a
  // zero-latency DUT can answer in the same cycle.
  assign head_v_s    = ~reset_i & (~tag_empty_s | dut_v_o);
  assign head_s      = tag_empty_s ? winner_s : fifo_head_s;
  assign dut_ready_o = head_v_s & resp_ready_i[head_s];
  assign hs_out_s    = dut_v_i & dut_ready_o;
  assign resp_data_o = dut_data_i;

  // A same-cycle request and response on an empty FIFO never touches storage.
  assign bypass_s = tag_empty_s & hs_in_s & hs_out_s;
  assign push_s   = hs_in_s & ~bypass_s;
  assign pop_s    = hs_out_s & ~tag_empty_s;

  // One-hot grant and response-valid steering.
  always_comb begin
    req_ready_o           = '0;
    resp_v_o              = '0;
    req_ready_o[winner_s] = ~reset_i & any_v_s & dut_ready_i & ~tag_full_s;
    resp_v_o[head_s]      = dut_v_i & head_v_s;
  end

  // Pointer moves past the winner only when a request is accepted.
  always_comb begin
    if (hs_in_s) begin
      ptr_d = (winner_s == last_req_lp) ? '0 : winner_s + tag_w_lp'(1'b1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  dut_rr_share_tag_fifo #(
    .els_p   (tag_els_p),
    .width_p (tag_w_lp)
  ) u_tag_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .data_i  (winner_s),
    .data_o  (fifo_head_s),
    .full_o  (tag_full_s),
    .empty_o (tag_empty_s),
    .count_o (tag_count_s)
  );

  dut_rr_share_chk #(
    .tag_els_p (tag_els_p),
    .cnt_w_p   (cnt_w_lp)
  ) u_chk (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .dut_v_i  (dut_v_i),
    .head_v_i (head_v_s),
    .count_i  (tag_count_s)
  );

endmodule

// File: tb/tb_dut_rr_share.sv
// Bench for dut_rr_share: a stand-in DUT (inverting, either pass-through or
// 2-cycle pipelined) plus a queue-based reference model of the sharer.
module tb_dut_rr_share;
  localparam int W = 80;
  localparam int N = 4;
  localparam int E = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset_i;
  logic [N-1:0]   req_v, req_ready_o, resp_v_o, resp_ready;
  logic [N*W-1:0] req_data;
  logic           dut_v_o, dut_ready_o, dut_ready_i, dut_v_i;
  logic [W-1:0]   dut_data_o, dut_data_i, resp_data_o;
  logic           pass_mode, dready;

  dut_rr_share #(.payload_width_p(W), .num_req_p(N), .tag_els_p(E)) u_dut (
    .clk_i(clk), .reset_i(reset_i), .req_v_i(req_v), .req_data_i(req_data),
    .req_ready_o(req_ready_o), .dut_v_o(dut_v_o), .dut_data_o(dut_data_o),
    .dut_ready_i(dut_ready_i), .dut_v_i(dut_v_i), .dut_data_i(dut_data_i),
    .dut_ready_o(dut_ready_o), .resp_v_o(resp_v_o), .resp_data_o(resp_data_o),
    .resp_ready_i(resp_ready)
  );

  // Stand-in DUT: inverts the payload; pipelined mode is a 2-cycle delay line.
  logic [W-1:0] p_mem [16];
  int           p_due [16];
  int           p_wr = 0, p_rd = 0, cyc = 0;
  logic         pipe_v;
  logic [W-1:0] pipe_d;

  always_comb begin
    pipe_v = (p_wr != p_rd) && (p_due[p_rd % 16] <= cyc);
    pipe_d = p_mem[p_rd % 16];
  end

  assign dut_ready_i = pass_mode ? dut_ready_o : dready;
  assign dut_v_i     = pass_mode ? dut_v_o : pipe_v;
  assign dut_data_i  = pass_mode ? ~dut_data_o : pipe_d;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset_i) begin
      p_wr <= 0;
      p_rd <= 0;
    end else begin
      if (!pass_mode && dut_v_o && dut_ready_i) begin
        p_mem[p_wr % 16] <= ~dut_data_o;
        p_due[p_wr % 16] <= cyc + 2;
        p_wr <= p_wr + 1;
      end
      if (!pass_mode && pipe_v && dut_ready_o) p_rd <= p_rd + 1;
    end
  end

  // Reference model state and per-cycle expectations.
  int           m_ptr = 0;
  int           tagq[$];
  logic [W-1:0] dq[$];
  int           e_w;
  logic         e_dut_v, e_dut_ready, e_hs_in, e_hs_out;
  logic [N-1:0] e_req_ready, e_resp_v;
  logic [W-1:0] e_resp_data;
  int           total = 0, bad = 0;

  function automatic logic [W-1:0] slice(int i);
    return req_data[i*W +: W];
  endfunction

  task automatic rand_data();
    for (int i = 0; i < N; i++) req_data[i*W +: W] = W'({$urandom(), $urandom(), $urandom()});
  endtask

  task automatic model_expect();
    int head;
    logic dvi, dri;
    e_w = -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (e_w < 0 && req_v[idx]) e_w = idx;
    end
    e_dut_v = 1'b0; e_dut_ready = 1'b0; e_hs_in = 1'b0; e_hs_out = 1'b0;
    e_req_ready = '0; e_resp_v = '0; e_resp_data = '0; head = -1;
    if (!reset_i) begin
      e_dut_v = (e_w >= 0) && (tagq.size() < E);
      if (tagq.size() > 0) begin
        head = tagq[0]; e_resp_data = dq[0];
      end else if (e_dut_v) begin
        head = e_w; e_resp_data = ~slice(e_w);
      end
      e_dut_ready = (head >= 0) && resp_ready[head];
      dri = pass_mode ? e_dut_ready : dready;
      dvi = pass_mode ? e_dut_v : pipe_v;
      if (e_dut_v && dri) e_req_ready[e_w] = 1'b1;
      if (dvi && head >= 0) e_resp_v[head] = 1'b1;
      e_hs_in  = e_dut_v && dri;
      e_hs_out = dvi && e_dut_ready;
    end
  endtask

  task automatic model_update();
    bit was_empty;
    if (reset_i) begin
      tagq.delete(); dq.delete(); m_ptr = 0;
    end else begin
      was_empty = (tagq.size() == 0);
      if (e_hs_out && !was_empty) begin
        void'(tagq.pop_front()); void'(dq.pop_front());
      end
      if (e_hs_in && !(was_empty && e_hs_out)) begin
        tagq.push_back(e_w); dq.push_back(~slice(e_w));
      end
      if (e_hs_in) m_ptr = (e_w + 1) % N;
    end
  endtask

  task automatic settle();
    #1;
    model_expect();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_i = 1'b1; pass_mode = 1'b1; dready = 1'b1;
    req_v = '1; resp_ready = '1; rand_data();
    @(negedge clk);
    repeat (2) begin
      settle();
      total++; if (dut_v_o !== 1'b0) begin bad++; $display("FAIL reset_dut_v: got %b want 0", dut_v_o); end
      total++; if (req_ready_o !== 4'b0000) begin bad++; $display("FAIL reset_req_ready: got %b want 0000", req_ready_o); end
      total++; if (dut_ready_o !== 1'b0) begin bad++; $display("FAIL reset_dut_ready: got %b want 0", dut_ready_o); end
      total++; if (resp_v_o !== 4'b0000) begin bad++; $display("FAIL reset_resp_v: got %b want 0000", resp_v_o); end
      tick();
    end
    reset_i = 1'b0; req_v = '0;
  endtask

  task automatic test_pass_single();
    logic [W-1:0] one;
    one = '0; one[0] = 1'b1;
    pass_mode = 1'b1; resp_ready = '1; req_v = 4'b0100; rand_data();
    req_data[2*W +: W] = one;
    settle();
    total++; if (dut_v_o !== 1'b1) begin bad++; $display("FAIL single_dut_v: got %b want 1", dut_v_o); end
    total++; if (req_ready_o !== 4'b0100) begin bad++; $display("FAIL single_req_ready: got %b want 0100", req_ready_o); end
    total++; if (resp_v_o !== 4'b0100) begin bad++; $display("FAIL single_resp_v: got %b want 0100", resp_v_o); end
    total++; if (resp_data_o !== ~one) begin bad++; $display("FAIL single_resp_data: got %h want %h", resp_data_o, ~one); end
    tick();
    total++; if (u_dut.tag_count_s !== 3'd0) begin bad++; $display("FAIL single_fifo_empty: got %0d want 0", u_dut.tag_count_s); end
    req_v = '0;
  endtask

  task automatic test_round_robin();
    int grants[N];
    int prev, g;
    prev = -1;
    for (int i = 0; i < N; i++) grants[i] = 0;
    pass_mode = 1'b1; resp_ready = '1; req_v = '1;
    for (int c = 0; c < 16; c++) begin
      rand_data();
      settle();
      g = -1;
      for (int i = 0; i < N; i++) if (req_ready_o == (4'b0001 << i)) g = i;
      total++; if (req_ready_o !== e_req_ready) begin bad++; $display("FAIL rr_grant: got %b want %b", req_ready_o, e_req_ready); end
      total++; if (resp_v_o !== e_req_ready) begin bad++; $display("FAIL rr_resp_v: got %b want %b", resp_v_o, e_req_ready); end
      total++; if (resp_data_o !== ~slice(e_w)) begin bad++; $display("FAIL rr_resp_data: got %h want %h", resp_data_o, ~slice(e_w)); end
      if (prev >= 0) begin
        total++; if (g != (prev + 1) % N) begin bad++; $display("FAIL rr_order: got %0d want %0d", g, (prev + 1) % N); end
      end
      if (g >= 0) grants[g]++;
      prev = g;
      tick();
    end
    for (int i = 0; i < N; i++) begin
      total++; if (grants[i] != 4) begin bad++; $display("FAIL rr_share[%0d]: got %0d want 4", i, grants[i]); end
    end
    req_v = '0;
  endtask

  task automatic test_hol_fill();
    pass_mode = 1'b0; dready = 1'b1; resp_ready = 4'b1110;
    req_v = 4'b0001; rand_data();
    settle();
    total++; if (req_ready_o !== 4'b0001) begin bad++; $display("FAIL hol_first: got %b want 0001", req_ready_o); end
    tick();
    req_v = 4'b1110;
    for (int c = 0; c < 8; c++) begin
      rand_data();
      settle();
      total++; if (dut_v_o !== e_dut_v) begin bad++; $display("FAIL hol_dut_v: got %b want %b", dut_v_o, e_dut_v); end
      total++; if (req_ready_o !== e_req_ready) begin bad++; $display("FAIL hol_req_ready: got %b want %b", req_ready_o, e_req_ready); end
      total++; if ((resp_v_o & 4'b1110) !== 4'b0000) begin bad++; $display("FAIL hol_resp_v: got %b want 000x", resp_v_o); end
      tick();
    end
    settle();
    total++; if (u_dut.tag_count_s !== 3'd4) begin bad++; $display("FAIL hol_count: got %0d want 4", u_dut.tag_count_s); end
    total++; if (dut_v_o !== 1'b0) begin bad++; $display("FAIL hol_full_v: got %b want 0", dut_v_o); end
    total++; if (req_ready_o !== 4'b0000) begin bad++; $display("FAIL hol_full_ready: got %b want 0000", req_ready_o); end
    total++; if (resp_v_o !== 4'b0001) begin bad++; $display("FAIL hol_blocked: got %b want 0001", resp_v_o); end
    resp_ready = '1; req_v = '0;
    for (int c = 0; c < 10; c++) begin
      settle();
      total++; if (resp_v_o !== e_resp_v) begin bad++; $display("FAIL drain_resp_v: got %b want %b", resp_v_o, e_resp_v); end
      if (e_resp_v != 4'b0000) begin
        total++; if (resp_data_o !== e_resp_data) begin bad++; $display("FAIL drain_data: got %h want %h", resp_data_o, e_resp_data); end
      end
      tick();
    end
    total++; if (u_dut.tag_count_s !== 3'd0) begin bad++; $display("FAIL drain_count: got %0d want 0", u_dut.tag_count_s); end
  endtask

  task automatic test_interleave();
    int order[4];
    logic [N-1:0] rec_v[8];
    logic [W-1:0] rec_d[8];
    logic [W-1:0] exp_d[4];
    logic [N-1:0] oh;
    int nrec;
    order = '{3, 1, 3, 0};
    nrec = 0;
    pass_mode = 1'b0; dready = 1'b1; resp_ready = '1;
    for (int c = 0; c < 10; c++) begin
      if (c < 4) begin
        oh = 4'b0001 << order[c];
        req_v = oh; rand_data(); exp_d[c] = ~slice(order[c]);
      end else begin
        req_v = '0;
      end
      settle();
      if (c < 4) begin
        total++; if (req_ready_o !== oh) begin bad++; $display("FAIL il_grant: got %b want %b", req_ready_o, oh); end
      end
      if (resp_v_o != 4'b0000 && dut_ready_o && nrec < 8) begin
        rec_v[nrec] = resp_v_o; rec_d[nrec] = resp_data_o; nrec++;
      end
      tick();
    end
    total++; if (nrec != 4) begin bad++; $display("FAIL il_count: got %0d want 4", nrec); end
    for (int i = 0; i < 4 && i < nrec; i++) begin
      oh = 4'b0001 << order[i];
      total++; if (rec_v[i] !== oh) begin bad++; $display("FAIL il_route[%0d]: got %b want %b", i, rec_v[i], oh); end
      total++; if (rec_d[i] !== exp_d[i]) begin bad++; $display("FAIL il_data[%0d]: got %h want %h", i, rec_d[i], exp_d[i]); end
    end
  endtask

  task automatic test_reset_midflight();
    int srcs[3];
    logic [W-1:0] want;
    bit got;
    srcs = '{0, 2, 3};
    got = 1'b0;
    pass_mode = 1'b0; dready = 1'b1; resp_ready = '0;
    for (int c = 0; c < 3; c++) begin
      req_v = 4'b0001 << srcs[c]; rand_data(); settle(); tick();
    end
    reset_i = 1'b1; req_v = '1; resp_ready = '1;
    settle();
    total++; if ({dut_v_o, dut_ready_o, req_ready_o, resp_v_o} !== 10'd0) begin bad++; $display("FAIL mid_reset_outs: got %b want 0", {dut_v_o, dut_ready_o, req_ready_o, resp_v_o}); end
    tick();
    reset_i = 1'b0; req_v = '0;
    total++; if (u_dut.tag_count_s !== 3'd0) begin bad++; $display("FAIL mid_count: got %0d want 0", u_dut.tag_count_s); end
    total++; if (u_dut.ptr_q !== 2'd0) begin bad++; $display("FAIL mid_ptr: got %0d want 0", u_dut.ptr_q); end
    req_v = 4'b0010; rand_data(); want = ~slice(1);
    settle();
    total++; if (req_ready_o !== 4'b0010) begin bad++; $display("FAIL mid_grant: got %b want 0010", req_ready_o); end
    tick();
    req_v = '0;
    for (int c = 0; c < 6; c++) begin
      settle();
      if (resp_v_o != 4'b0000) begin
        got = 1'b1;
        total++; if (resp_v_o !== 4'b0010) begin bad++; $display("FAIL mid_route: got %b want 0010", resp_v_o); end
        total++; if (resp_data_o !== want) begin bad++; $display("FAIL mid_data: got %h want %h", resp_data_o, want); end
      end
      tick();
    end
    total++; if (!got) begin bad++; $display("FAIL mid_no_resp: got none want one"); end
  endtask

  task automatic test_full_pop();
    pass_mode = 1'b0; dready = 1'b1; resp_ready = '0; req_v = '1;
    for (int c = 0; c < 6; c++) begin rand_data(); settle(); tick(); end
    settle();
    total++; if (u_dut.tag_count_s !== 3'd4) begin bad++; $display("FAIL fp_count_full: got %0d want 4", u_dut.tag_count_s); end
    resp_ready = '1;
    settle();
    total++; if (dut_ready_o !== 1'b1) begin bad++; $display("FAIL fp_pop: got %b want 1", dut_ready_o); end
    total++; if (dut_v_o !== 1'b0) begin bad++; $display("FAIL fp_blocked: got %b want 0", dut_v_o); end
    total++; if (req_ready_o !== 4'b0000) begin bad++; $display("FAIL fp_req_ready: got %b want 0000", req_ready_o); end
    tick();
    total++; if (u_dut.tag_count_s !== 3'd3) begin bad++; $display("FAIL fp_count3: got %0d want 3", u_dut.tag_count_s); end
    settle();
    total++; if (dut_v_o !== 1'b1 || req_ready_o !== e_req_ready || e_req_ready == 4'b0000) begin bad++; $display("FAIL fp_push: got v=%b rdy=%b want v=1 rdy=%b", dut_v_o, req_ready_o, e_req_ready); end
    tick();
    req_v = '0;
    for (int c = 0; c < 12; c++) begin
      settle();
      total++; if (resp_v_o !== e_resp_v) begin bad++; $display("FAIL fp_drain: got %b want %b", resp_v_o, e_resp_v); end
      tick();
    end
    total++; if (u_dut.tag_count_s !== 3'(tagq.size())) begin bad++; $display("FAIL fp_final: got %0d want %0d", u_dut.tag_count_s, tagq.size()); end
  endtask

  task automatic test_random();
    pass_mode = 1'b0;
    for (int c = 0; c < 400; c++) begin
      reset_i = ($urandom_range(0, 63) == 0);
      req_v   = 4'($urandom());
      for (int i = 0; i < N; i++) resp_ready[i] = ($urandom_range(0, 3) != 0);
      dready  = ($urandom_range(0, 3) != 0);
      rand_data();
      settle();
      total++; if (dut_v_o !== e_dut_v) begin bad++; $display("FAIL rnd_dut_v: got %b want %b", dut_v_o, e_dut_v); end
      total++; if (req_ready_o !== e_req_ready) begin bad++; $display("FAIL rnd_req_ready: got %b want %b", req_ready_o, e_req_ready); end
      total++; if (dut_ready_o !== e_dut_ready) begin bad++; $display("FAIL rnd_dut_ready: got %b want %b", dut_ready_o, e_dut_ready); end
      total++; if (resp_v_o !== e_resp_v) begin bad++; $display("FAIL rnd_resp_v: got %b want %b", resp_v_o, e_resp_v); end
      if (e_resp_v != 4'b0000) begin
        total++; if (resp_data_o !== e_resp_data) begin bad++; $display("FAIL rnd_resp_data: got %h want %h", resp_data_o, e_resp_data); end
      end
      if (e_dut_v) begin
        total++; if (dut_data_o !== slice(e_w)) begin bad++; $display("FAIL rnd_dut_data: got %h want %h", dut_data_o, slice(e_w)); end
      end
      tick();
    end
    reset_i = 1'b0; req_v = '0; resp_ready = '1;
    for (int c = 0; c < 12; c++) begin
      settle();
      total++; if (resp_v_o !== e_resp_v) begin bad++; $display("FAIL rnd_drain: got %b want %b", resp_v_o, e_resp_v); end
      tick();
    end
  endtask

  initial begin
    reset_i = 1'b1; req_v = '0; resp_ready = '0; req_data = '0;
    pass_mode = 1'b1; dready = 1'b1;
    test_reset();
    test_pass_single();
    test_round_robin();
    test_hol_fill();
    test_interleave();
    test_reset_midflight();
    test_full_pop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dut_rr_share.md
Name: dut_rr_share

Overview:
Shares one valid/ready payload datapath (the DUT: arbitrary latency, in-order, one response per request) among num_req_p requesters. Round-robin arbiter on the request side; in-order tag FIFO routes each DUT response back to the requester that issued it. Sits between trace-replay requesters and the DUT in the test harness. Supports both pass-through (0-cycle) and pipelined DUTs.

Parameters:
payload_width_p, 80, request/response payload width
num_req_p, 4, number of requesters (>=2)
tag_els_p, 4, max in-flight requests (tag FIFO depth, >=2)

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
req_v_i  in  num_req_p  per-requester valid
req_data_i  in  num_req_p*payload_width_p  per-requester payload, requester i at slice i
req_ready_o  out  num_req_p  per-requester ready
dut_v_o  out  1  valid to DUT input
dut_data_o  out  payload_width_p  payload to DUT
dut_ready_i  in  1  DUT input ready
dut_v_i  in  1  DUT output valid
dut_data_i  in  payload_width_p  DUT output payload
dut_ready_o  out  1  ready to DUT output
resp_v_o  out  num_req_p  per-requester response valid
resp_data_o  out  payload_width_p  response payload, broadcast to all requesters
resp_ready_i  in  num_req_p  per-requester response ready

Behaviour:
- Reset: rr pointer=0, tag FIFO empty. While reset_i=1, all outputs forced to 0: req_ready_o, dut_v_o, dut_ready_o, resp_v_o. Reset mid-transfer drops all in-flight tags. The DUT is reset alongside.
- Arbitration: winner = first i with req_v_i[i]=1, searching from ptr upward, mod num_req_p. Combinational, no cycle of latency.
- dut_v_o = (|req_v_i) & ~tag_full. dut_data_o = req_data_i[winner]. dut_v_o never depends on dut_ready_i.
- req_ready_o[winner] = dut_ready_i & ~tag_full. All other req_ready_o bits are 0.
- Request handshake (hs_in = dut_v_o & dut_ready_i):
  - push winner index into the tag FIFO;
  - ptr <= (winner+1) mod num_req_p;
  - with no hs_in, ptr holds.
- Tag FIFO is full when it holds tag_els_p entries. Full blocks new requests even if a pop occurs that cycle, so there is no full-bypass.
- Effective head tag:
  - if the FIFO is non-empty: FIFO head;
  - if empty and dut_v_o=1: winner (empty-bypass, required for a 0-latency DUT);
  - otherwise: no head.
- dut_ready_o = head exists & resp_ready_i[head]. dut_ready_o never depends on dut_v_i, so there is no loop through a pass-through DUT.
- resp_v_o[head] = dut_v_i & head exists. All other bits are 0. resp_data_o = dut_data_i.
- Response handshake (hs_out = dut_v_i & dut_ready_o) pops the head.
- FIFO update cases:
  - empty, hs_in & hs_out same cycle: FIFO stays empty (bypass consumed);
  - non-empty, push & pop same cycle: count unchanged, pointers both advance;
  - push only: count+1;
  - pop only: count-1.
- Read/write pointers wrap modulo tag_els_p; count width is clog2(tag_els_p+1).
- DUT response with no head (dut_v_i=1, FIFO empty, no request this cycle) is a protocol error. Assertion fires; dut_ready_o=0.
- Responses are delivered strictly in request order. A stalled requester (resp_ready_i=0) blocks all responses behind it: head-of-line blocking by design.

Decomposition:
- Package dut_rr_share_pkg:
  - tag width constant, clog2(num_req_p);
  - count width helper;
  - tag typedef.
- Sub-module dut_rr_share_tag_fifo holds the tag_els_p x tag-width storage, pointers and count, plus full/empty outputs and a simultaneous push/pop port.
- The round-robin select stays inline in the top module.

Test Plan:
- Pass-through inverting DUT; only requester 2 sends 0x1 with resp_ready all 1 -> same cycle: dut_v_o=1, req_ready_o=4'b0100, resp_v_o=4'b0100, resp_data_o=~0x1; FIFO stays empty.
- All 4 requesters valid continuously, pass-through DUT -> grants cycle 0,1,2,3,0,...; each requester gets exactly 1 of every 4 handshakes.
- 2-cycle pipelined DUT, resp_ready_i=0 for requester 0 after it issues, others keep issuing -> FIFO fills to 4; dut_v_o and all req_ready_o drop to 0; no resp_v_o except bit 0. Releasing resp_ready_i[0] drains in order.
- Interleaved issue order 3,1,3,0 through the pipelined DUT -> resp_v_o one-hot sequence 1000,0010,1000,0001 with matching payloads.
- Assert reset_i with 3 tags in flight -> next cycle all outputs 0, count=0, ptr=0; the first post-reset request from requester 1 is granted and routed correctly.
- Full FIFO with a pop and a requester valid in the same cycle -> pop occurs, push is blocked, count=3; the push succeeds the following cycle.
